lcd_frame_serializer: RTL and testbench

Downstream of the display control block. Takes the six registered ASCII display characters and the six annunciator/punctuation flags, and decides when the external LCD controller needs a new frame. When it does, it shifts one 56-bit frame out MSB-first over a 3-wire serial link (sclk/sdo/cs_n). A frame is sent only when the display content changes or a refresh is requested. Inputs are snapshotted at frame start, so content cannot tear mid-frame.

---
 rtl/lcd_frame_serializer.sv | 206 ++++++++++++++++++++
 tb/tb_lcd_frame_serializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_serializer.sv
// ---------------------------------------------------------------------------
// lcd_frame_serializer
//
// Purpose:
//   Packs the six display characters and six annunciator/punctuation flags
//   into a 56-bit frame and shifts it MSB-first to an external LCD
//   controller over a 3-wire link (sclk/sdo/cs_n). A frame is sent only
//   when the content differs from what was last sent, when a refresh is
//   requested, or once after reset. The content is snapshotted at frame
//   start, so input changes during a frame cannot tear it.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous reset, active low
//   refresh      single-cycle pulse, forces a resend of the current content
//   lower0001..lower1000, upper01, upper10   ASCII characters (8 bits each)
//   AVS, DAY, MAX, TIM, col, point           flags (1 bit each)
//   sclk         serial clock, idles low
//   sdo          serial data, changes on sclk falling edge
//   cs_n         frame strobe, active low; the slave latches on its rise
//   busy         high for the whole frame including the trailing gap
//   frame_done   one-cycle pulse when cs_n returns high
//
// Parameter:
//   CLK_DIV      sclk half-period in clock cycles (1..255)
// ---------------------------------------------------------------------------
module lcd_frame_serializer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       refresh,
  input  logic [7:0] lower0001,
  input  logic [7:0] lower0010,
  input  logic [7:0] lower0100,
  input  logic [7:0] lower1000,
  input  logic [7:0] upper01,
  input  logic [7:0] upper10,
  input  logic       AVS,
  input  logic       DAY,
  input  logic       MAX,
  input  logic       TIM,
  input  logic       col,
  input  logic       point,
  output logic       sclk,
  output logic       sdo,
  output logic       cs_n,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'd55;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    LATCH = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t      state, state_nxt;

  logic [55:0] live_vec;
  logic [55:0] shreg, shreg_nxt;
  logic [55:0] shadow, shadow_nxt;
  logic [7:0]  div_cnt, div_nxt;
  logic [5:0]  bit_cnt, bit_nxt;
  logic        pending, pending_nxt;
  logic        sclk_nxt, sdo_nxt, cs_n_nxt, busy_nxt, frame_done_nxt;
  logic        tick;
  logic        start;
  logic        last_fall;

  assign live_vec = {upper10, upper01, lower1000, lower0100, lower0010, lower0001,
                     AVS, DAY, MAX, TIM, col, point, 2'b00};

  // Every phase (setup, each sclk half-period, latch, gap) is CLK_DIV long.
  assign tick      = (div_cnt == DIV_LAST);
  assign start     = pending | refresh | (live_vec != shadow);
  assign last_fall = sclk & (bit_cnt == BIT_LAST);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   if (tick) state_nxt = SHIFT;
      SHIFT:   if (tick && last_fall) state_nxt = LATCH;
      LATCH:   if (tick) state_nxt = GAP;
      GAP:     if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values; everything below is registered.
  always_comb begin
    sclk_nxt       = sclk;
    sdo_nxt        = sdo;
    cs_n_nxt       = cs_n;
    busy_nxt       = busy;
    frame_done_nxt = 1'b0;
    shreg_nxt      = shreg;
    shadow_nxt     = shadow;
    pending_nxt    = pending;
    div_nxt        = div_cnt;
    bit_nxt        = bit_cnt;

    if (state != IDLE) begin
      div_nxt = tick ? 8'd0 : div_cnt + 8'd1;
      // A refresh during a frame is remembered; repeated pulses collapse.
      if (refresh) pending_nxt = 1'b1;
    end

    unique case (state)
      IDLE: begin
        div_nxt  = 8'd0;
        bit_nxt  = 6'd0;
        sclk_nxt = 1'b0;
        if (start) begin
          shreg_nxt   = live_vec;
          shadow_nxt  = live_vec;
          pending_nxt = 1'b0;
          cs_n_nxt    = 1'b0;
          sdo_nxt     = live_vec[55];
          busy_nxt    = 1'b1;
        end else begin
          cs_n_nxt = 1'b1;
          sdo_nxt  = 1'b0;
          busy_nxt = 1'b0;
        end
      end
      SETUP: begin
        if (tick) sclk_nxt = 1'b1;
      end
      SHIFT: begin
        if (tick) begin
          if (sclk) begin
            // Falling edge: advance to the next bit. The register rotates
            // so its contents stay intact; sdo is forced low after bit 0.
            sclk_nxt  = 1'b0;
            bit_nxt   = bit_cnt + 6'd1;
            shreg_nxt = {shreg[54:0], shreg[55]};
            sdo_nxt   = last_fall ? 1'b0 : shreg[54];
          end else begin
            sclk_nxt = 1'b1;
          end
        end
      end
      LATCH: begin
        if (tick) begin
          cs_n_nxt       = 1'b1;
          frame_done_nxt = 1'b1;
        end
      end
      GAP: begin
        if (tick) busy_nxt = 1'b0;
      end
      default: begin
        cs_n_nxt = 1'b1;
        sclk_nxt = 1'b0;
        sdo_nxt  = 1'b0;
        busy_nxt = 1'b0;
      end
    endcase
  end

  // Output / datapath registers. Pending resets high so the first frame
  // after reset is always sent; async reset idles the link immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sclk       <= 1'b0;
      sdo        <= 1'b0;
      cs_n       <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shreg      <= '0;
      shadow     <= '0;
      pending    <= 1'b1;
      div_cnt    <= '0;
      bit_cnt    <= '0;
    end else begin
      sclk       <= sclk_nxt;
      sdo        <= sdo_nxt;
      cs_n       <= cs_n_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
      shreg      <= shreg_nxt;
      shadow     <= shadow_nxt;
      pending    <= pending_nxt;
      div_cnt    <= div_nxt;
      bit_cnt    <= bit_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_lcd_frame_serializer
//
// Directed bench for lcd_frame_serializer with CLK_DIV = 4. A single
// sampling task advances one clock and decodes the serial link on the
// falling clock edge (captured sdo bits at each sclk rise, sclk rise count,
// frame_done count, cs_n low cycles).
// ---------------------------------------------------------------------------
module tb_lcd_frame_serializer;

  localparam int D = 4;

  logic       clock;
  logic       reset;
  logic       refresh;
  logic [7:0] lower0001, lower0010, lower0100, lower1000, upper01, upper10;
  logic       AVS, DAY, MAX, TIM, col, point;
  logic       sclk, sdo, cs_n, busy, frame_done;

  lcd_frame_serializer #(.CLK_DIV(D)) dut (
    .clock      (clock),
    .reset      (reset),
    .refresh    (refresh),
    .lower0001  (lower0001),
    .lower0010  (lower0010),
    .lower0100  (lower0100),
    .lower1000  (lower1000),
    .upper01    (upper01),
    .upper10    (upper10),
    .AVS        (AVS),
    .DAY        (DAY),
    .MAX        (MAX),
    .TIM        (TIM),
    .col        (col),
    .point      (point),
    .sclk       (sclk),
    .sdo        (sdo),
    .cs_n       (cs_n),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [55:0] cap;
  int          rises;
  int          frames;
  int          cs_low_cnt;
  logic        prev_cs_n;
  logic        prev_sclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    if (!reset) begin
      prev_cs_n = 1'b1;
      prev_sclk = 1'b0;
    end else begin
      if (prev_cs_n && !cs_n) begin
        cap   = '0;
        rises = 0;
      end
      if (sclk && !prev_sclk) begin
        cap = {cap[54:0], sdo};
        rises++;
      end
      if (frame_done) frames++;
      if (!cs_n) cs_low_cnt++;
      prev_cs_n = cs_n;
      prev_sclk = sclk;
    end
  endtask

  // From a start trigger: wait for cs_n to fall, then for frame_done and
  // busy falling, checking the cycle distances and the captured frame.
  task automatic run_frame(input string tag, input int exp_start, input logic [55:0] exp_vec);
    int n;
    n = 0;
    while (cs_n !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_start_lat"}, n, exp_start);
    check({tag, "_busy_hi"}, busy, 1'b1);
    n = 0;
    while (frame_done !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    check({tag, "_done_lat"}, n, 113 * D);
    check({tag, "_cs_at_done"}, cs_n, 1'b1);
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_idle_lat"}, n, D);
    check({tag, "_rises"}, rises, 56);
    check({tag, "_data"}, cap, exp_vec);
  endtask

  initial begin
    int n;
    int f0;
    reset      = 1'b1;
    refresh    = 1'b0;
    lower0001  = 8'h00; lower0010 = 8'h00; lower0100 = 8'h00; lower1000 = 8'h00;
    upper01    = 8'h00; upper10   = 8'h00;
    AVS = 1'b0; DAY = 1'b0; MAX = 1'b0; TIM = 1'b0; col = 1'b0; point = 1'b0;
    cap = '0; rises = 0; frames = 0; cs_low_cnt = 0;
    prev_cs_n = 1'b1; prev_sclk = 1'b0;
    #1 reset = 1'b0;

    // Reset values
    repeat (3) step();
    check("rst_sclk", sclk, 1'b0);
    check("rst_sdo", sdo, 1'b0);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);

    // First frame after reset release: 56 zero bits
    reset = 1'b1;
    run_frame("boot", 1, 56'h0);
    repeat (100) step();
    check("boot_frames", frames, 1);
    check("boot_idle_cs", cs_n, 1'b1);

    // "12 3.4" with DAY and point
    upper10 = 8'h31; upper01 = 8'h32; lower1000 = 8'h20;
    lower0100 = 8'h33; lower0010 = 8'h2E; lower0001 = 8'h34;
    DAY = 1'b1; point = 1'b1;
    run_frame("text", 1, 56'h313220332E3444);

    // Constant inputs: link stays idle
    f0 = frames;
    cs_low_cnt = 0;
    repeat (10000) step();
    check("hold_frames", frames - f0, 0);
    check("hold_cs_low", cs_low_cnt, 0);

    // Change lower0001 at rising edge 20 of a frame
    lower0001 = 8'h30;
    n = 0;
    while (cs_n !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    check("chg1_start_lat", n, 1);
    n = 0;
    while (rises < 21 && n < 500) begin
      step();
      n++;
    end
    check("chg1_rise20", rises, 21);
    lower0001 = 8'h31;
    n = 0;
    while (frame_done !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    check("chg1_done", frame_done, 1'b1);
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    check("chg1_idle_lat", n, D);
    check("chg1_data", cap, 56'h313220332E3044);
    run_frame("chg2", 1, 56'h313220332E3144);

    // Refresh in idle, then three refreshes during the frame
    repeat (10) step();
    f0 = frames;
    refresh = 1'b1;
    step();
    refresh = 1'b0;
    check("ref_cs_fall", cs_n, 1'b0);
    repeat (3) begin
      repeat (60) step();
      refresh = 1'b1;
      step();
      refresh = 1'b0;
    end
    repeat (1000) step();
    check("ref_frames", frames - f0, 2);
    check("ref_idle_busy", busy, 1'b0);
    check("ref_idle_cs", cs_n, 1'b1);
    check("ref_data", cap, 56'h313220332E3144);

    // Reset asserted at rising edge 30
    refresh = 1'b1;
    step();
    refresh = 1'b0;
    n = 0;
    while (rises < 31 && n < 1000) begin
      step();
      n++;
    end
    check("mid_rise30", rises, 31);
    check("mid_sclk_hi", sclk, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_cs_n", cs_n, 1'b1);
    check("mid_sclk", sclk, 1'b0);
    check("mid_sdo", sdo, 1'b0);
    check("mid_busy", busy, 1'b0);
    repeat (2) step();
    reset = 1'b1;
    f0 = frames;
    run_frame("post_rst", 1, 56'h313220332E3144);
    repeat (50) step();
    check("post_rst_frames", frames - f0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
